// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: mode encodings, byte type and the
// ShiftRows per-row offset table for Rijndael block widths.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_FWD = 2'b00,
    MODE_INV = 2'b01,
    MODE_BYP = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef logic [7:0] byte_t;

  // Rijndael offsets: rows 2 and 3 shift one extra column at NB=8.
  function automatic int unsigned shift_offset(input int unsigned nb, input int unsigned row);
    if (nb == 8 && row >= 2) return row + 1;
    return row;
  endfunction

endpackage

// File: rtl/shift_rows_core.sv
// Combinational ShiftRows / InvShiftRows / bypass permutation for an NB-column state.
// Byte k of the state (column k/4, row k%4) sits at bits [8k:8k+7].
module shift_rows_core
  import aes_pkg::*;
#(
  parameter int unsigned NB = 4
) (
  input  logic [0:32*NB-1] Data_In,
  input  logic [1:0]       Mode,
  output logic [0:32*NB-1] Data_Out
);

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned S   = shift_offset(NB, r);
      localparam int unsigned FWD = (c + S) % NB;
      localparam int unsigned INV = (c + NB - S) % NB;

      byte_t b_fwd, b_inv, b_same;

      assign b_fwd  = Data_In[8*(4*FWD+r) +: 8];
      assign b_inv  = Data_In[8*(4*INV+r) +: 8];
      assign b_same = Data_In[8*(4*c+r) +: 8];

      // Bypass and reserved modes both pass the byte straight through.
      assign Data_Out[8*(4*c+r) +: 8] = (Mode == MODE_FWD) ? b_fwd :
                                        (Mode == MODE_INV) ? b_inv : b_same;
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered valid/ready ShiftRows stage. Define SHIFT_ROWS_SKID_EN to add a
// 1-entry skid buffer so In_Ready becomes a pure register output.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [0:32*NB-1]     Data_In,
  input  logic [1:0]           Mode,
  input  logic [TAG_W-1:0]     Tag_In,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  output logic [0:32*NB-1]     Data_Out,
  output logic [TAG_W-1:0]     Tag_Out,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic                 Mode_Err
);

  if (NB != 4 && NB != 6 && NB != 8) begin : g_nb_check
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [0:32*NB-1] shifted;
  logic             mode_err_in;
  logic             accept;
  logic             load_main;

  logic             src_valid;
  logic [0:32*NB-1] src_data;
  logic [TAG_W-1:0] src_tag;
  logic             src_err;

  shift_rows_core #(.NB(NB)) u_core (
    .Data_In  (Data_In),
    .Mode     (Mode),
    .Data_Out (shifted)
  );

  assign mode_err_in = (Mode == MODE_RSV);
  assign accept      = In_Valid && In_Ready;
  assign load_main   = !Out_Valid || Out_Ready;

`ifdef SHIFT_ROWS_SKID_EN
  logic             skid_valid;
  logic [0:32*NB-1] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;

  assign In_Ready = !skid_valid;

  // Skid only fills when the main register is held; it empties on the next drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
    end else if (load_main) begin
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= shifted;
      skid_tag   <= Tag_In;
      skid_err   <= mode_err_in;
    end
  end

  always_comb begin
    src_valid = skid_valid || accept;
    src_data  = shifted;
    src_tag   = Tag_In;
    src_err   = mode_err_in;
    if (skid_valid) begin
      src_data = skid_data;
      src_tag  = skid_tag;
      src_err  = skid_err;
    end
  end
`else
  assign In_Ready = load_main;

  always_comb begin
    src_valid = accept;
    src_data  = shifted;
    src_tag   = Tag_In;
    src_err   = mode_err_in;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out_Valid <= 1'b0;
      Data_Out  <= '0;
      Tag_Out   <= '0;
      Mode_Err  <= 1'b0;
    end else if (load_main) begin
      Out_Valid <= src_valid;
      if (src_valid) begin
        Data_Out <= src_data;
        Tag_Out  <= src_tag;
        Mode_Err <= src_err;
      end
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe (NB=4 and NB=8 instances) against a
// byte-array reference model of ShiftRows.
module tb_shift_rows_pipe;

  localparam int unsigned TAG_W = 4;
`ifdef SHIFT_ROWS_SKID_EN
  localparam int STALL_ACC = 2;
`else
  localparam int STALL_ACC = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:127]     a_din, a_dout;
  logic [1:0]       a_mode;
  logic [TAG_W-1:0] a_tin, a_tout;
  logic             a_iv, a_ir, a_ov, a_or, a_err;

  logic [0:255]     b_din, b_dout;
  logic [1:0]       b_mode;
  logic [TAG_W-1:0] b_tin, b_tout;
  logic             b_iv, b_ir, b_ov, b_or, b_err;

  int tests = 0;
  int fails = 0;

  shift_rows_pipe #(.NB(4), .TAG_W(TAG_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .Data_In(a_din), .Mode(a_mode), .Tag_In(a_tin),
    .In_Valid(a_iv), .In_Ready(a_ir), .Data_Out(a_dout), .Tag_Out(a_tout),
    .Out_Valid(a_ov), .Out_Ready(a_or), .Mode_Err(a_err)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(TAG_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .Data_In(b_din), .Mode(b_mode), .Tag_In(b_tin),
    .In_Valid(b_iv), .In_Ready(b_ir), .Data_Out(b_dout), .Tag_Out(b_tout),
    .Out_Valid(b_ov), .Out_Ready(b_or), .Mode_Err(b_err)
  );

  // Reference: rebuild the state as a [row][col] byte matrix and rotate each row.
  function automatic logic [0:255] ref_shift(input int nb, input logic [0:255] din, input logic [1:0] mode);
    logic [7:0]   m [4][8];
    logic [0:255] res;
    int           off [4];
    int           src;
    if (nb == 8) off = '{0, 1, 3, 4};
    else         off = '{0, 1, 2, 3};
    res = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = din[8*(4*c+r) +: 8];
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        if (mode == 2'b00)      src = (c + off[r]) % nb;
        else if (mode == 2'b01) src = (c - off[r] + nb) % nb;
        else                    src = c;
        res[8*(4*c+r) +: 8] = m[r][src];
      end
    return res;
  endfunction

  function automatic logic [0:127] ref4(input logic [0:127] d, input logic [1:0] mode);
    logic [0:255] t;
    t = ref_shift(4, {d, 128'h0}, mode);
    return t[0:127];
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Call just after driving inputs at a negedge; samples handshake and outputs
  // before the next posedge, then returns at the following negedge.
  task automatic tick_a(output bit acc, output bit drn, output logic [0:127] od,
                        output logic [TAG_W-1:0] ot, output logic oe);
    #1;
    acc = a_iv && a_ir;
    drn = a_ov && a_or;
    od  = a_dout;
    ot  = a_tout;
    oe  = a_err;
    @(negedge clk);
  endtask

  task automatic tick_b(output bit drn, output logic [0:255] od);
    #1;
    drn = b_ov && b_or;
    od  = b_dout;
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_din = '0; a_mode = '0; a_tin = '0; a_iv = 1'b0; a_or = 1'b0;
    b_din = '0; b_mode = '0; b_tin = '0; b_iv = 1'b0; b_or = 1'b0;
    rst_n = 1'b0;
    #2;
    tests++; if (a_ov !== 1'b0)   begin fails++; $display("FAIL reset_out_valid: got %b expected 0", a_ov); end
    tests++; if (a_dout !== '0)   begin fails++; $display("FAIL reset_data: got %h expected 0", a_dout); end
    tests++; if (a_tout !== '0)   begin fails++; $display("FAIL reset_tag: got %h expected 0", a_tout); end
    tests++; if (a_err !== 1'b0)  begin fails++; $display("FAIL reset_mode_err: got %b expected 0", a_err); end
    tests++; if (a_ir !== 1'b1)   begin fails++; $display("FAIL reset_in_ready: got %b expected 1", a_ir); end
    tests++; if (b_ov !== 1'b0)   begin fails++; $display("FAIL reset_nb8_out_valid: got %b expected 0", b_ov); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips();
    logic [0:127]     vin [4];
    logic [0:127]     vexp[4];
    logic [1:0]       vm  [4];
    bit               acc, drn;
    logic [0:127]     od;
    logic [TAG_W-1:0] ot;
    logic             oe;
    vin[0] = 128'hd42711aee0bf98f1b8b45de51e415230; vm[0] = 2'b00; vexp[0] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    vin[1] = 128'hd4bf5d30e0b452aeb84111f11e2798e5; vm[1] = 2'b01; vexp[1] = 128'hd42711aee0bf98f1b8b45de51e415230;
    vin[2] = rnd128();                               vm[2] = 2'b10; vexp[2] = vin[2];
    vin[3] = rnd128();                               vm[3] = 2'b11; vexp[3] = vin[3];
    a_or = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_din = vin[i]; a_mode = vm[i]; a_tin = 4'(i + 5); a_iv = 1'b1;
      tick_a(acc, drn, od, ot, oe);
      tests++; if (acc !== 1'b1) begin fails++; $display("FAIL fips_accept[%0d]: got %b expected 1", i, acc); end
      a_iv = 1'b0; a_din = rnd128(); a_mode = 2'b00;
      tick_a(acc, drn, od, ot, oe);
      tests++; if (drn !== 1'b1) begin fails++; $display("FAIL fips_latency[%0d]: out_valid %b expected 1", i, drn); end
      tests++; if (od !== vexp[i]) begin fails++; $display("FAIL fips_data[%0d]: got %h expected %h", i, od, vexp[i]); end
      tests++; if (ot !== 4'(i + 5)) begin fails++; $display("FAIL fips_tag[%0d]: got %h expected %h", i, ot, 4'(i + 5)); end
      tests++; if (oe !== (i == 3)) begin fails++; $display("FAIL fips_mode_err[%0d]: got %b expected %b", i, oe, (i == 3)); end
    end
  endtask

  task automatic test_nb8();
    logic [0:255] orig, fwd, od, expv;
    bit           drn;
    for (int k = 0; k < 32; k++) orig[8*k +: 8] = 8'(k);
    b_or = 1'b1;
    b_din = orig; b_mode = 2'b00; b_iv = 1'b1;
    tick_b(drn, od);
    b_iv = 1'b0;
    tick_b(drn, fwd);
    expv = ref_shift(8, orig, 2'b00);
    tests++; if (drn !== 1'b1) begin fails++; $display("FAIL nb8_fwd_valid: got %b expected 1", drn); end
    for (int k = 0; k < 32; k++) begin
      tests++;
      if (fwd[8*k +: 8] !== expv[8*k +: 8]) begin
        fails++; $display("FAIL nb8_fwd_byte[%0d]: got %h expected %h", k, fwd[8*k +: 8], expv[8*k +: 8]);
      end
    end
    // Row 2 col 0 comes from col 3 (byte 0x0e); row 3 col 0 from col 4 (byte 0x13).
    tests++; if (fwd[16 +: 8] !== 8'h0e) begin fails++; $display("FAIL nb8_row2_shift3: got %h expected 0e", fwd[16 +: 8]); end
    tests++; if (fwd[24 +: 8] !== 8'h13) begin fails++; $display("FAIL nb8_row3_shift4: got %h expected 13", fwd[24 +: 8]); end
    b_din = fwd; b_mode = 2'b01; b_iv = 1'b1;
    tick_b(drn, od);
    b_iv = 1'b0;
    tick_b(drn, od);
    tests++; if (od !== orig) begin fails++; $display("FAIL nb8_inverse: got %h expected %h", od, orig); end
    for (int i = 0; i < 4; i++) begin
      b_din = {rnd128(), rnd128()}; b_mode = 2'($urandom_range(0, 3)); b_iv = 1'b1;
      expv = ref_shift(8, b_din, b_mode);
      tick_b(drn, od);
      b_iv = 1'b0;
      tick_b(drn, od);
      tests++; if (od !== expv) begin fails++; $display("FAIL nb8_random[%0d]: got %h expected %h", i, od, expv); end
    end
  endtask

  task automatic test_stall();
    logic [0:127]     sd [3];
    logic [1:0]       sm [3];
    logic [0:127]     exp_d[$];
    logic [TAG_W-1:0] exp_t[$];
    logic [0:127]     od, ed;
    logic [TAG_W-1:0] ot, et;
    logic             oe;
    bit               acc, drn;
    int               idx, got;
    for (int i = 0; i < 3; i++) begin sd[i] = rnd128(); sm[i] = 2'($urandom_range(0, 1)); end
    a_or = 1'b0; idx = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      a_din = sd[idx]; a_mode = sm[idx]; a_tin = 4'(idx + 1); a_iv = 1'b1;
      tick_a(acc, drn, od, ot, oe);
      if (acc) begin exp_d.push_back(ref4(sd[idx], sm[idx])); exp_t.push_back(4'(idx + 1)); idx++; end
    end
    tests++; if (idx !== STALL_ACC) begin fails++; $display("FAIL stall_accepted: got %0d expected %0d", idx, STALL_ACC); end
    tests++; if (a_ir !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b expected 0", a_ir); end
    tests++; if (a_ov !== 1'b1 || a_tout !== 4'd1) begin fails++; $display("FAIL stall_hold: valid %b tag %h expected 1 1", a_ov, a_tout); end
    a_or = 1'b1; got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      if (idx < 3) begin a_din = sd[idx]; a_mode = sm[idx]; a_tin = 4'(idx + 1); a_iv = 1'b1; end
      else a_iv = 1'b0;
      tick_a(acc, drn, od, ot, oe);
      if (acc) begin exp_d.push_back(ref4(sd[idx], sm[idx])); exp_t.push_back(4'(idx + 1)); idx++; end
      if (drn) begin
        ed = exp_d.pop_front(); et = exp_t.pop_front(); got++;
        tests++; if (od !== ed) begin fails++; $display("FAIL stall_order_data[%0d]: got %h expected %h", got, od, ed); end
        tests++; if (ot !== et) begin fails++; $display("FAIL stall_order_tag[%0d]: got %h expected %h", got, ot, et); end
      end
    end
    a_iv = 1'b0;
    tests++; if (got !== 3) begin fails++; $display("FAIL stall_drain_count: got %0d expected 3", got); end
  endtask

  task automatic test_back_to_back();
    logic [0:127]     exp_d[$];
    logic [TAG_W-1:0] exp_t[$];
    logic             exp_e[$];
    logic [0:127]     od, ed;
    logic [TAG_W-1:0] ot, et;
    logic             oe, ee;
    bit               acc, drn;
    int               ndrn;
    a_iv = 1'b0; a_or = 1'b1;
    tick_a(acc, drn, od, ot, oe);
    tick_a(acc, drn, od, ot, oe);
    ndrn = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_iv = (cyc < 16); a_din = rnd128(); a_mode = 2'($urandom_range(0, 3)); a_tin = 4'($urandom());
      if (a_iv) begin exp_d.push_back(ref4(a_din, a_mode)); exp_t.push_back(a_tin); exp_e.push_back(a_mode == 2'b11); end
      tick_a(acc, drn, od, ot, oe);
      tests++; if (acc !== (cyc < 16)) begin fails++; $display("FAIL b2b_accept[%0d]: got %b expected %b", cyc, acc, (cyc < 16)); end
      tests++; if (drn !== (cyc >= 1 && cyc <= 16)) begin fails++; $display("FAIL b2b_out_valid[%0d]: got %b expected %b", cyc, drn, (cyc >= 1 && cyc <= 16)); end
      if (drn && exp_d.size() > 0) begin
        ed = exp_d.pop_front(); et = exp_t.pop_front(); ee = exp_e.pop_front(); ndrn++;
        tests++;
        if (od !== ed || ot !== et || oe !== ee) begin
          fails++; $display("FAIL b2b_data[%0d]: got %h/%h/%b expected %h/%h/%b", cyc, od, ot, oe, ed, et, ee);
        end
      end
    end
    a_iv = 1'b0;
    tests++; if (ndrn !== 16) begin fails++; $display("FAIL b2b_count: got %0d expected 16", ndrn); end
  endtask

  task automatic test_reset_mid();
    logic [0:127]     od, d0, ed;
    logic [TAG_W-1:0] ot;
    logic             oe;
    bit               acc, drn;
    a_or = 1'b0; a_iv = 1'b1; a_mode = 2'b11; a_din = rnd128(); a_tin = 4'hA;
    tick_a(acc, drn, od, ot, oe);
    a_din = rnd128(); a_tin = 4'hB;
    tick_a(acc, drn, od, ot, oe);
    a_iv = 1'b0;
    tests++; if (a_ov !== 1'b1) begin fails++; $display("FAIL rmid_pre_valid: got %b expected 1", a_ov); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (a_ov !== 1'b0)  begin fails++; $display("FAIL rmid_out_valid: got %b expected 0", a_ov); end
    tests++; if (a_dout !== '0)  begin fails++; $display("FAIL rmid_data: got %h expected 0", a_dout); end
    tests++; if (a_tout !== '0 || a_err !== 1'b0) begin fails++; $display("FAIL rmid_tag_err: got %h/%b expected 0/0", a_tout, a_err); end
    tests++; if (a_ir !== 1'b1)  begin fails++; $display("FAIL rmid_in_ready: got %b expected 1", a_ir); end
    @(negedge clk);
    rst_n = 1'b1;
    a_or = 1'b1; a_iv = 1'b1; a_mode = 2'b00; d0 = rnd128(); a_din = d0; a_tin = 4'h3;
    ed = ref4(d0, 2'b00);
    tick_a(acc, drn, od, ot, oe);
    a_iv = 1'b0;
    tick_a(acc, drn, od, ot, oe);
    tests++; if (drn !== 1'b1 || od !== ed || ot !== 4'h3) begin fails++; $display("FAIL rmid_first_after: got %b %h %h expected 1 %h 3", drn, od, ot, ed); end
    tick_a(acc, drn, od, ot, oe);
    tests++; if (drn !== 1'b0) begin fails++; $display("FAIL rmid_no_stale: got %b expected 0", drn); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fips();
    test_nb8();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
